// File: rtl/seq_mul.sv
// Sequential radix-2 shift-add multiplier over a 4-bit CLA slice chain; WIDTH cycles per product.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands using radix-2 Booth recoding.
`timescale 1ns/1ps

module seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam int unsigned SLICES = WIDTH / 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, done_q;

  logic [WIDTH-1:0]     add_b;
  logic                 add_ci;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic                 carry;
  logic                 shift_msb;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g, p;
    logic       c1, c2, c3, c4;
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

`ifdef SEQ_MUL_SIGNED_EN
  logic qm1_q, qm1_d;

  always_comb begin
    add_b  = '0;
    add_ci = 1'b0;
    case ({lo_q[0], qm1_q})
      2'b01:   add_b = mcand_q;
      2'b10: begin
        add_b  = ~mcand_q;
        add_ci = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  // True sign of the (WIDTH+1)-bit sum, immune to overflow of the WIDTH-bit adder.
  assign shift_msb = hi_q[WIDTH-1] ^ add_b[WIDTH-1] ^ cout;
`else
  always_comb begin
    add_b  = lo_q[0] ? mcand_q : '0;
    add_ci = 1'b0;
  end

  assign shift_msb = cout;
`endif

  always_comb begin
    sum   = '0;
    carry = add_ci;
    for (int unsigned s = 0; s < SLICES; s++) begin
      {carry, sum[4*s +: 4]} = cla4(hi_q[4*s +: 4], add_b[4*s +: 4], carry);
    end
    cout = carry;
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef SEQ_MUL_SIGNED_EN
    qm1_d    = qm1_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = multiplicand;
          hi_d    = '0;
          lo_d    = multiplier;
          cnt_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
          qm1_d   = 1'b0;
`endif
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        hi_d  = {shift_msb, sum[WIDTH-1:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_MUL_SIGNED_EN
        qm1_d = lo_q[0];
`endif
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = {hi_d, lo_d};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      qm1_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d == S_EXEC);
      done_q   <= (state_d == S_DONE);
`ifdef SEQ_MUL_SIGNED_EN
      qm1_q    <= qm1_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed and random checks of seq_mul: latency, busy window, back-to-back starts, ignored starts, async reset.
// Honours SEQ_MUL_SIGNED_EN for expected values.
`timescale 1ns/1ps

module tb_seq_mul;

  localparam int unsigned W   = 8;
  localparam int unsigned PER = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  time         t_done_last = 0;

  seq_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ax, bx;
`ifdef SEQ_MUL_SIGNED_EN
    ax = {{W{a[W-1]}}, a};
    bx = {{W{b[W-1]}}, b};
`else
    ax = {{W{1'b0}}, a};
    bx = {{W{1'b0}}, b};
`endif
    return ax * bx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle k+1 after the accepting edge k.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
  endtask

  task automatic expect_op(input string tag, input logic [2*W-1:0] exp, input int lat0);
    int lat;
    int nbusy;
    lat   = lat0;
    nbusy = 0;
    while (!done && lat <= int'(W) + 3) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, lat, W + 1);
    check_eq({tag, "_busy"}, nbusy, W + 1 - lat0);
    check_eq({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_res"}, {16'd0, result}, {16'd0, exp});
    t_done_last = $time;
  endtask

  task automatic idle_check(input string tag, input logic [2*W-1:0] exp);
    tick();
    check_eq({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_held"}, {16'd0, result}, {16'd0, exp});
  endtask

  initial begin
    logic [W-1:0] corner [4];
    logic [W-1:0] a, b;
    time          t1;
    int           ndone;

    corner = '{8'h00, 8'h01, 8'h7F, 8'h80};
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) tick();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", {16'd0, result}, 32'd0);
    reset = 1'b0;
    tick();

`ifdef SEQ_MUL_SIGNED_EN
    issue(8'hFF, 8'hFF); expect_op("ff_ff", 16'h0001, 1); idle_check("ff_ff", 16'h0001);
`else
    issue(8'hFF, 8'hFF); expect_op("ff_ff", 16'hFE01, 1); idle_check("ff_ff", 16'hFE01);
`endif

    issue(8'h00, 8'hA5); expect_op("zero", 16'h0000, 1);
    t1 = t_done_last;
    issue(8'h0D, 8'h0B); expect_op("b2b", 16'h008F, 1);
    check_eq("b2b_gap", int'((t_done_last - t1) / PER), W + 1);
    idle_check("b2b", 16'h008F);

    issue(8'h12, 8'h34);
    tick();
    tick();
    mcand  = 8'hFF;
    mplier = 8'hFF;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    expect_op("ign", 16'h03A8, 4);
    idle_check("ign", 16'h03A8);

    issue(8'h55, 8'h55);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    check_eq("arst_result", {16'd0, result}, 32'd0);
    tick();
    reset = 1'b0;
    ndone = 0;
    repeat (W + 4) begin
      if (done) ndone++;
      tick();
    end
    check_eq("arst_no_done", ndone, 0);
    issue(8'h03, 8'h05); expect_op("after_rst", 16'h000F, 1); idle_check("after_rst", 16'h000F);

`ifdef SEQ_MUL_SIGNED_EN
    issue(8'h80, 8'h80); expect_op("s_80_80", 16'h4000, 1); idle_check("s_80_80", 16'h4000);
    issue(8'hFF, 8'h01); expect_op("s_ff_01", 16'hFFFF, 1); idle_check("s_ff_01", 16'hFFFF);
    issue(8'h7F, 8'h80); expect_op("s_7f_80", 16'hC080, 1); idle_check("s_7f_80", 16'hC080);
    issue(8'hFD, 8'h06); expect_op("s_fd_06", 16'hFFEE, 1); idle_check("s_fd_06", 16'hFFEE);
`endif

    for (int i = 0; i < 2000; i++) begin
      if (i < 16) begin
        a = corner[i % 4];
        b = corner[i / 4];
      end else begin
        a = W'($urandom);
        b = W'($urandom);
      end
      issue(a, b);
      expect_op("rnd", ref_mul(a, b), 1);
      if ($urandom_range(1) == 0) idle_check("rnd", ref_mul(a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Sequential radix-2 multiplier that builds a 2·WIDTH-bit product over WIDTH clock cycles. It uses one WIDTH-bit adder, built as a chain of 4-bit carry-lookahead slices. The block sits directly upstream of the multiplier's adder stage: each cycle it drives the adder operands and carry-in, then shifts the returned sum and carry-out into its partial-product register. It replaces the array multiplier wherever area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand width; multiple of 4 (adder built from 4-bit CLA slices); product width 2·WIDTH.

Ports. One clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  WIDTH  operand A; captured on accepted start.
- multiplier  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while in EXEC.
- done  output  1  one-cycle pulse; result valid.
- result  output  2·WIDTH  product; held until the next completion.

## Operation
- State machine: IDLE → EXEC → DONE → IDLE. State encoding is free.
- IDLE:
  - start=1 captures both operands.
  - Initialises the partial-product register: hi = 0, lo = multiplier, count = 0.
  - Enters EXEC.
- EXEC, one iteration per cycle, count 0..WIDTH-1:
  - Unsigned build: if lo[0]=1, then {cout, sum} = hi + multiplicand via the CLA chain (ci=0); otherwise sum = hi and cout = 0.
  - Unsigned shift: {cout, sum, lo} shifts right by 1 into {hi, lo}.
  - After iteration WIDTH-1, go to DONE and load result = {hi, lo}.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start=1 in DONE is accepted as in IDLE, giving back-to-back operation with no idle bubble; the next state is EXEC.
- start while in EXEC is ignored. Operands are not re-sampled and no error is flagged.
- Operand inputs may change freely after the accepting edge.
- Arithmetic: the product is exact; no truncation or overflow is possible at 2·WIDTH bits.
- Reset (any time, including mid-EXEC): state=IDLE, busy=0, done=0, result=0, partial-product register=0, count=0. An aborted operation produces no done pulse.

## Timing
- Edge k samples start=1 (state IDLE or DONE).
- busy=1 in cycles k+1 .. k+WIDTH.
- done=1 and result valid in cycle k+WIDTH+1. Latency is WIDTH+1 cycles from start to done.
- result changes only on the edge that enters DONE, or on reset.
- Maximum throughput with start held high: one product per WIDTH+1 cycles.
- The adder path is the critical path: one WIDTH-bit CLA chain plus a 2:1 mux per cycle, with no combinational path from inputs to outputs.
- All outputs are registered.

## Configuration
- Macro: SEQ_MUL_SIGNED_EN.
- Defined: operands and result are two's complement, using radix-2 Booth recoding.
  - Extra flop q_m1 is initialised to 0.
  - Each iteration examines {lo[0], q_m1}:
    - 01: hi + multiplicand.
    - 10: hi + ~multiplicand with ci=1.
    - 00 or 11: hi unchanged.
  - Shift is arithmetic right using the sum's sign-corrected MSB, not cout. q_m1 takes the outgoing lo[0].
  - Latency is unchanged.
- Undefined: unsigned shift-add as described in Operation; q_m1 and the subtract path are absent.

## Test plan
- Reset, then start with multiplicand=0xFF, multiplier=0xFF (unsigned build) → done in cycle k+9, result=0xFE01, busy high for 8 cycles.
- multiplicand=0x00, multiplier=0xA5, then a back-to-back start in DONE with 0x0D, 0x0B → first result=0x0000, second result=0x008F; done pulses exactly 9 cycles apart.
- Start 0x12, 0x34; pulse start again at cycle k+3 with 0xFF, 0xFF → the second start is ignored; result=0x03A8.
- Start 0x55, 0x55; assert reset at cycle k+4 → busy, done and result go to 0 immediately (asynchronously); no done pulse; a fresh start of 0x03, 0x05 then gives 0x000F.
- SEQ_MUL_SIGNED_EN defined:
  - 0x80 × 0x80 → 0x4000.
  - 0xFF × 0x01 → 0xFFFF.
  - 0x7F × 0x80 → 0xC080.
  - 0xFD × 0x06 → 0xFFEE.
- Random sweep, 2000 operand pairs in each build, compared against a reference model: every result matches, and each done pulse is single-cycle at latency WIDTH+1.
